fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
IF stage sitting between the PC counter and the IF/ID boundary of the MIPS pipeline. Consumes prog_count, runs a req/ready transaction to instruction memory, and loads the IF/ID pipeline register. Drives next_pc/pc_write back into the counter for sequential advance, branch redirect and stall hold. Drops in-flight fetches on redirect and buffers an instruction that arrives while the pipeline is stalled.

Parameters:
NOP_INSTR, 32'h00000000, instruction inserted into IF/ID on flush/reset
PC_INC, 4, sequential PC increment (bytes)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
prog_count  in  32  current PC from counter
stall  in  1  hazard unit: hold PC and IF/ID
branch_taken  in  1  redirect request (single-cycle pulse)
branch_target  in  32  redirect address, valid with branch_taken
imem_req  out  1  memory request
imem_addr  out  32  memory address; stable while imem_req high
imem_ready  in  1  memory response valid / transfer complete (req & ready)
imem_rdata  in  32  instruction word, valid with imem_ready
next_pc  out  32  next PC to counter (combinational)
pc_write  out  1  counter load enable (combinational, one-cycle pulse)
if_id_valid  out  1  IF/ID holds a real instruction
if_id_instr  out  32  IF/ID instruction
if_id_pc_plus4  out  32  IF/ID fetch address + 4
stall_cycles  out  16  cycles with pc_write=0, saturating

Behaviour:
- Reset (sync, priority over everything): state=S_ISSUE, addr_q=0, buffer=NOP_INSTR, if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc_plus4=0, stall_cycles=0. While reset is high: imem_req=0, pc_write=0, next_pc=0.
- Memory protocol: once imem_req rises, it stays high with imem_addr unchanged until imem_ready. ready is allowed in the same cycle as req, giving zero-wait throughput of 1 instr/cycle.
- S_ISSUE: imem_req=1, imem_addr=prog_count, addr_q<=prog_count. If ready, run ACCEPT. Else go to S_WAIT.
- S_WAIT: imem_req=1, imem_addr=addr_q. If ready, run ACCEPT.
- ACCEPT, in priority order:
  - branch_taken: pc_write=1, next_pc=branch_target, flush IF/ID (valid=0, instr=NOP_INSTR), go to S_ISSUE.
  - else stall: buffer<=imem_rdata, pc_write=0, IF/ID holds, go to S_HOLD.
  - else: IF/ID<=(1, imem_rdata, addr+PC_INC), pc_write=1, next_pc=addr+PC_INC, go to S_ISSUE.
- S_HOLD: imem_req=0.
  - branch_taken: discard buffer, redirect and flush as above, go to S_ISSUE.
  - else stall released: IF/ID<=(1, buffer, addr_q+PC_INC), pc_write=1, next_pc=addr_q+PC_INC, go to S_ISSUE.
- Branch in S_ISSUE/S_WAIT without ready: pc_write=1, next_pc=branch_target, flush IF/ID, go to S_DROP. The outstanding request continues with addr_q.
- S_DROP: imem_req=1, imem_addr=addr_q. On ready, discard rdata, pc_write=0, go to S_ISSUE. A further branch here re-redirects (pc_write=1, new target) and stays in S_DROP. If ready and branch occur together, redirect and go to S_ISSUE.
- branch_taken and stall together: branch wins. Flush clears IF/ID regardless of stall.
- Stall with no ACCEPT: IF/ID holds value; FSM unaffected.
- PC arithmetic is modulo 2^32: 0xFFFFFFFC+4 wraps to 0x00000000. No alignment checking.
- stall_cycles increments every non-reset cycle with pc_write=0 and saturates at 0xFFFF.
- Latency: zero-wait memory gives PC in at cycle N and IF/ID valid at edge N+1. The counter updates at the same edge, so the next request issues in cycle N+1.

Decomposition:
- Shared package mips_pkg holds NOP_INSTR, PC_INC and the fetch state encoding (S_ISSUE, S_WAIT, S_HOLD, S_DROP).
- One sub-module, if_id_reg: IF/ID pipeline register with load/hold/flush controls and a flush-over-hold priority.
- FSM, address latch, buffer and stall counter stay in fetch_stage.

Test Plan:
- Zero-wait: ready tied 1, counter model from 0. Expected: pc_write every cycle, imem_addr 0,4,8,12; if_id_pc_plus4 4,8,12,16; stall_cycles stays 0.
- Wait states: addr 0x40, ready asserted after 3 cycles. Expected: imem_req high 4 cycles with addr 0x40 stable; a single pc_write with next_pc=0x44.
- Stall on arrival: stall=1 when 0x8C220004 returns for 0x10. Expected: pc_write=0, req=0 in HOLD. Stall drops 2 cycles later. Expected: if_id_instr=0x8C220004, pc_plus4=0x14, pc_write pulse with next_pc=0x14.
- Branch mid-wait: in S_WAIT at 0x20, branch_taken to 0x100. Expected: pc_write with next_pc=0x100, if_id_valid=0, addr held at 0x20 until ready, rdata dropped, then req at 0x100.
- Wrap: prog_count=0xFFFFFFFC, zero-wait. Expected: next_pc=0x00000000, if_id_pc_plus4=0.
- Reset mid-S_WAIT. Expected: next cycle imem_req=1 at current prog_count, if_id_valid=0, stall_cycles=0; a late ready during reset is ignored.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch constants and fetch FSM state encoding
package mips_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INC = 32'd4;
  typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_HOLD, S_DROP} fetch_state_t;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory bus; master drives req/addr, slave returns ready/rdata
interface fetch_stage_if;
  logic req;
  logic [31:0] addr;
  logic ready;
  logic [31:0] rdata;
  modport master(output req, addr, input ready, rdata);
  modport slave(input req, addr, output ready, rdata);
endinterface

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register; ports clock/reset, load/hold/flush controls (flush > hold > load), load data in, valid/instr/pc_plus4 out
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        hold,
  input  logic        flush,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc_plus4,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4
);
  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pc_plus4 <= 32'h0;
    end else if (flush) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end else if (load && !hold) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc_plus4 <= load_pc_plus4;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage; ports clock/reset, prog_count/stall/branch in, imem master bus, next_pc/pc_write to counter, IF/ID outputs, stall_cycles
module fetch_stage
  import mips_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [31:0]        prog_count,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  fetch_stage_if.master      imem,
  output logic [31:0]        next_pc,
  output logic               pc_write,
  output logic               if_id_valid,
  output logic [31:0]        if_id_instr,
  output logic [31:0]        if_id_pc_plus4,
  output logic [15:0]        stall_cycles
);
  fetch_state_t state, state_d;
  logic [31:0] addr_q, buffer, cur, inc;
  logic fetching, accept, hold, advance;
  always_comb begin
    fetching = state == S_ISSUE || state == S_WAIT;
    accept = fetching && imem.ready;
    hold = state == S_HOLD;
    cur = state == S_ISSUE ? prog_count : addr_q;
    inc = cur + PC_INC;
    advance = !branch_taken && !stall && (accept || hold);
    state_d = fetching ? (accept ? (!branch_taken && stall ? S_HOLD : S_ISSUE)
                                 : (branch_taken ? S_DROP : S_WAIT))
            : hold ? (branch_taken || !stall ? S_ISSUE : S_HOLD)
            : (imem.ready ? S_ISSUE : S_DROP);
  end
  assign imem.req = !reset && !hold;
  assign imem.addr = cur;
  assign pc_write = !reset && (branch_taken || advance);
  assign next_pc = reset ? 32'h0 : branch_taken ? branch_target : inc;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_ISSUE;
      addr_q <= 32'h0;
      buffer <= NOP_INSTR;
      stall_cycles <= 16'h0;
    end else begin
      state <= state_d;
      if (state == S_ISSUE) addr_q <= prog_count;
      if (accept && !branch_taken && stall) buffer <= imem.rdata;
      if (!pc_write && !(&stall_cycles)) stall_cycles <= stall_cycles + 16'd1;
    end
  end
  if_id_reg u_if_id (
    .clock(clock),
    .reset(reset),
    .load(advance),
    .hold(stall),
    .flush(branch_taken),
    .load_instr(hold ? buffer : imem.rdata),
    .load_pc_plus4(inc),
    .valid(if_id_valid),
    .instr(if_id_instr),
    .pc_plus4(if_id_pc_plus4)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized fetch_stage bench against a transaction-level model
module tb_fetch_stage;
  import mips_pkg::*;
  logic clock = 0, reset = 1, stall = 0, branch_taken = 0;
  logic [31:0] branch_target = 0, prog_count = 0, next_pc, if_id_instr, if_id_pc_plus4;
  logic pc_write, if_id_valid;
  logic [15:0] stall_cycles;
  fetch_stage_if imem();
  fetch_stage dut (
    .clock(clock), .reset(reset), .prog_count(prog_count), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target), .imem(imem),
    .next_pc(next_pc), .pc_write(pc_write), .if_id_valid(if_id_valid),
    .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4), .stall_cycles(stall_cycles)
  );
  always #5 clock = ~clock;
  int total = 0, bad = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] memf(input logic [31:0] a);
    return a == 32'h10 ? 32'h8C22_0004 : (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  logic buffered = 0, stale = 0, cont = 0, m_valid = 0, pw_s = 0;
  logic [31:0] buf_pc = 0, prev_addr = 0, exp_pc = 0, m_instr = 0, m_pc4 = 0, np_s = 0;
  logic [15:0] m_sc = 0;
  int mwait = 0, lat_max = 0;
  // One clock cycle, entered and left at posedge+1.
  task automatic cyc(input logic rs, input logic st, input logic br, input logic [31:0] tgt, input logic lr);
    logic deliver, exp_pw;
    logic [31:0] da;
    reset = rs; stall = st; branch_taken = br; branch_target = tgt;
    #1;
    imem.ready = (imem.req && mwait == 0) || lr;
    imem.rdata = imem.req && imem.ready ? memf(imem.addr) : $urandom;
    #1;
    deliver = 0; da = 0;
    if (rs) begin
      check("rst_req", imem.req, 0);
      check("rst_pw", pc_write, 0);
      check("rst_np", next_pc, 0);
    end else begin
      check("req", imem.req, !buffered);
      if (imem.req) check("addr", imem.addr, cont ? prev_addr : prog_count);
      if (imem.req && imem.ready) begin
        if (!stale && !br) begin
          if (st) begin buffered = 1; buf_pc = imem.addr; end
          else begin deliver = 1; da = imem.addr; end
        end
        stale = 0;
      end else if (imem.req && br) stale = 1;
      else if (!imem.req && buffered) begin
        if (br) buffered = 0;
        else if (!st) begin deliver = 1; da = buf_pc; buffered = 0; end
      end
      exp_pw = br || deliver;
      check("pw", pc_write, exp_pw);
      if (br) check("np_br", next_pc, tgt);
      else if (deliver) check("np_seq", next_pc, da + 4);
      if (deliver) begin
        check("order", da, exp_pc);
        exp_pc = da + 4; m_valid = 1; m_instr = memf(da); m_pc4 = da + 4;
      end
      if (br) begin exp_pc = tgt; m_valid = 0; m_instr = NOP_INSTR; end
      if (!exp_pw && m_sc != 16'hFFFF) m_sc++;
      if (imem.req) begin
        if (imem.ready) mwait = $urandom_range(0, lat_max);
        else if (mwait > 0) mwait--;
      end
    end
    cont = !rs && imem.req && !imem.ready;
    prev_addr = imem.addr;
    pw_s = pc_write; np_s = next_pc;
    @(posedge clock); #1;
    if (rs) begin
      buffered = 0; stale = 0; cont = 0; m_valid = 0; m_instr = NOP_INSTR; m_pc4 = 0; m_sc = 0;
      exp_pc = prog_count;
      check("rst_pc4", if_id_pc_plus4, 0);
    end else if (pw_s) prog_count = np_s;
    check("v", if_id_valid, m_valid);
    check("instr", if_id_instr, m_instr);
    if (m_valid) check("pc4", if_id_pc_plus4, m_pc4);
    check("sc", stall_cycles, m_sc);
    imem.ready = 0;
  endtask
  int n, idle, max_idle;
  logic st_r;
  initial begin
    imem.ready = 0; imem.rdata = 0;
    @(posedge clock); #1;
    // zero-wait from 0
    prog_count = 0; lat_max = 0; mwait = 0;
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0);
      check("zw_pc4", if_id_pc_plus4, 32'(4 * (i + 1)));
      check("zw_sc", stall_cycles, 0);
    end
    // wait states at 0x40
    prog_count = 32'h40;
    cyc(1, 0, 0, 0, 0);
    mwait = 3; n = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0);
      n += int'(pw_s);
    end
    check("ws_pw", n, 1);
    check("ws_pc", prog_count, 32'h44);
    // stall on arrival at 0x10
    prog_count = 32'h10;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    check("st_pw", pw_s, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("st_instr", if_id_instr, 32'h8C22_0004);
    check("st_pc4", if_id_pc_plus4, 32'h14);
    check("st_pc", prog_count, 32'h14);
    // branch while waiting at 0x20
    prog_count = 32'h20;
    cyc(1, 0, 0, 0, 0);
    mwait = 3;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h100, 0);
    check("br_pc", prog_count, 32'h100);
    check("br_v", if_id_valid, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("br_pc4", if_id_pc_plus4, 32'h104);
    check("br_instr", if_id_instr, memf(32'h100));
    // wrap
    prog_count = 32'hFFFF_FFFC;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("wr_np", np_s, 0);
    check("wr_pc4", if_id_pc_plus4, 0);
    // reset mid-wait with a late ready
    mwait = 5;
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    check("rw_v", if_id_valid, 0);
    check("rw_sc", stall_cycles, 0);
    mwait = 0;
    cyc(0, 0, 0, 0, 0);
    // randomized traffic
    idle = 0; max_idle = 0; st_r = 0;
    for (int i = 0; i < 600; i++) begin
      logic rs, br;
      logic [31:0] tgt;
      if (i % 100 == 0) lat_max = $urandom_range(0, 3);
      rs = $urandom_range(0, 99) == 0;
      st_r = $urandom_range(0, 3) == 0 ? ~st_r : st_r;
      br = $urandom_range(0, 11) == 0;
      tgt = $urandom_range(0, 15) == 0 ? 32'hFFFF_FFF8 : {22'h0, 8'($urandom), 2'b00};
      if (rs) mwait = $urandom_range(0, lat_max);
      cyc(rs, st_r, br, tgt, 0);
      idle = (pw_s || rs || st_r) ? 0 : idle + 1;
      if (idle > max_idle) max_idle = idle;
    end
    check("live", max_idle > 40, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
